// File: rtl/uart_dist_rx.sv
// Purpose : 8N1 UART receiver that pairs low/high bytes into 16-bit distance words.
// Latency : 2-cycle input sync; rx_byte_valid 1 cycle after the mid-stop sample, distance_valid 1 cycle later.
// Backpressure: none, the line cannot be stalled; outputs are single-cycle strobes that must be captured.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   uart_rx         serial input, idle high, asynchronous to clk
//   rx_byte/_valid  last correctly framed byte + one-cycle strobe
//   distance_data/_valid  reassembled word {high, low} + one-cycle strobe
//   frame_err       one-cycle strobe on a low stop bit
// Optional: define UART_DIST_RX_TIMEOUT_EN to drop a pending low byte after
//   TIMEOUT_BITS idle bit-times between the low and high byte of one word.
module uart_dist_rx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic [15:0] distance_data,
  output logic        distance_valid,
  output logic        frame_err
);

  localparam int BIT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int TMR_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_DIV - 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(BIT_DIV / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic [TMR_W-1:0] tmr_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             byte_idx_q;
  logic [7:0]       low_q;
  logic             tmr_clr, bit_take, byte_ok, byte_bad;
  logic             to_expire;

  // rx_prev is the edge-detect history of the synchronised line, not a third sync stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b0;
    bit_take = 1'b0;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = START;
          tmr_clr = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a line already back high was only a glitch.
        if (tmr_q == HALF_LAST) begin
          tmr_clr = 1'b1;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr_q == BIT_LAST) begin
          tmr_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tmr_q == BIT_LAST) begin
          tmr_clr = 1'b1;
          if (rx_sync) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            byte_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line recovers so a break yields a single frame_err.
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer is parked at zero whenever no bit is being timed, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (tmr_clr || state_q == IDLE || state_q == WAIT_HIGH) tmr_q <= '0;
      else                                                    tmr_q <= tmr_q + 1'b1;
      if (state_q == START)  bit_cnt_q <= '0;
      else if (bit_take)     bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_take)          shift_q   <= {rx_sync, shift_q[7:1]};
    end
  end

`ifdef UART_DIST_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * BIT_DIV;
  localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Only idle time with a low byte pending counts; a frame in progress pauses it.
  assign to_expire = byte_idx_q && (state_q == IDLE) && (to_cnt_q == TO_W'(TO_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                to_cnt_q <= '0;
    else if (rx_byte_valid || to_expire)       to_cnt_q <= '0;
    else if (byte_idx_q && state_q == IDLE)    to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  // TIMEOUT_BITS has no effect in this build; the term folds to constant 0.
  assign to_expire = (TIMEOUT_BITS < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte        <= '0;
      rx_byte_valid  <= 1'b0;
      frame_err      <= 1'b0;
      distance_data  <= '0;
      distance_valid <= 1'b0;
      byte_idx_q     <= 1'b0;
      low_q          <= '0;
    end else begin
      rx_byte_valid  <= byte_ok;
      frame_err      <= byte_bad;
      distance_valid <= 1'b0;
      if (byte_ok) rx_byte <= shift_q;
      // Word assembly runs one cycle behind the byte strobe.
      if (byte_bad) begin
        byte_idx_q <= 1'b0;
      end else if (rx_byte_valid) begin
        if (!byte_idx_q) begin
          low_q      <= rx_byte;
          byte_idx_q <= 1'b1;
        end else begin
          distance_data  <= {rx_byte, low_q};
          distance_valid <= 1'b1;
          byte_idx_q     <= 1'b0;
        end
      end else if (to_expire) begin
        byte_idx_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_dist_rx.sv
// Purpose : directed + randomised bench for uart_dist_rx with a byte/word scoreboard.
// Latency : line is driven in time units so baud offsets need not align to clk.
// Backpressure: none; every DUT strobe is popped against the expectation queues.
module tb_uart_dist_rx;

  localparam int CLK_FREQ  = 1843200;
  localparam int BAUD_RATE = 115200;
  localparam int BIT_DIV   = CLK_FREQ / BAUD_RATE;   // 16
  localparam int HALF_CLK  = 50;
  localparam int BT        = BIT_DIV * 2 * HALF_CLK; // nominal bit time

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [15:0] distance_data;
  logic        distance_valid;
  logic        frame_err;

  always #HALF_CLK clk = ~clk;

  uart_dist_rx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD_RATE    (BAUD_RATE),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx        (uart_rx),
    .rx_byte        (rx_byte),
    .rx_byte_valid  (rx_byte_valid),
    .distance_data  (distance_data),
    .distance_valid (distance_valid),
    .frame_err      (frame_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fe_cnt    = 0;

  logic [7:0]  bq[$];
  logic [15:0] wq[$];
  bit          m_idx = 1'b0;
  logic [7:0]  m_low = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference pairing: low byte first, high byte completes the word.
  task automatic model_byte(input logic [7:0] b);
    bq.push_back(b);
    if (!m_idx) begin
      m_low = b;
      m_idx = 1'b1;
    end else begin
      wq.push_back({b, m_low});
      m_idx = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int bt);
    if (stop_ok) model_byte(b);
    else         m_idx = 1'b0;
    uart_rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #(bt);
    end
    uart_rx = stop_ok;
    #(bt);
    uart_rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 * BIT_DIV && (bq.size() != 0 || wq.size() != 0); i++)
      @(posedge clk);
    chk(tag, bq.size() + wq.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rx_byte"},        rx_byte,        8'h00);
    chk({tag, "_rx_byte_valid"},  rx_byte_valid,  1'b0);
    chk({tag, "_distance_data"},  distance_data,  16'h0000);
    chk({tag, "_distance_valid"}, distance_valid, 1'b0);
    chk({tag, "_frame_err"},      frame_err,      1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_byte_valid) begin
        chk("byte_expected", bq.size() > 0, 1);
        if (bq.size() > 0) chk("rx_byte", rx_byte, bq.pop_front());
      end
      if (distance_valid) begin
        chk("word_expected", wq.size() > 0, 1);
        if (wq.size() > 0) chk("distance_data", distance_data, wq.pop_front());
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #(60000 * 2 * HALF_CLK);
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w;
    int          bt;

    // Reset state
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back pair at nominal rate
    send_byte(8'h34, 1'b1, BT);
    send_byte(8'h12, 1'b1, BT);
    drain("t1_drain");
    chk("t1_dist", distance_data, 16'h1234);
    chk("t1_fe_cnt", fe_cnt, 0);

    // Bad stop bit discards the byte and restarts pairing
    send_byte(8'hA5, 1'b0, BT);
    #(BT);
    send_byte(8'h01, 1'b1, BT);
    send_byte(8'h00, 1'b1, BT);
    drain("t2_drain");
    chk("t2_fe_cnt", fe_cnt, 1);
    chk("t2_dist", distance_data, 16'h0001);

    // Short low glitch shorter than half a bit must be rejected
    uart_rx = 1'b0;
    repeat (5) @(posedge clk);
    uart_rx = 1'b1;
    #(3 * BT);
    chk("t3_fe_cnt", fe_cnt, 1);
    chk("t3_no_byte", bq.size(), 0);
    send_byte(8'h5A, 1'b1, BT);
    send_byte(8'hC3, 1'b1, BT);
    drain("t3_drain");
    chk("t3_dist", distance_data, 16'hC35A);

    // Long gap between low and high byte
    send_byte(8'h11, 1'b1, BT);
    #(25 * BT);
`ifdef UART_DIST_RX_TIMEOUT_EN
    m_idx = 1'b0;
`endif
    send_byte(8'h22, 1'b1, BT);
    send_byte(8'h33, 1'b1, BT);
    drain("t4_drain");
`ifdef UART_DIST_RX_TIMEOUT_EN
    chk("t4_dist", distance_data, 16'h3322);
`else
    chk("t4_dist", distance_data, 16'h2211);
`endif

    // Reset during bit 4 of the second byte
    send_byte(8'h9A, 1'b1, BT);
    drain("t5_first_drain");
    uart_rx = 1'b0;
    #(BT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = i[0];
      #(BT);
    end
    uart_rx = 1'b1;
    #(BT / 2);
    rst_n = 1'b0;
    m_idx = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("t5_in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h78, 1'b1, BT);
    send_byte(8'h56, 1'b1, BT);
    drain("t5_drain");
    chk("t5_dist", distance_data, 16'h5678);

    // Random words with up to +/-2% baud offset
    for (int n = 0; n < 32; n++) begin
      w  = 16'($urandom);
      bt = BT - 32 + int'($urandom_range(64, 0));
      send_byte(w[7:0],  1'b1, bt);
      send_byte(w[15:8], 1'b1, bt);
      #(BT);
    end
    drain("t6_drain");
    chk("t6_fe_cnt", fe_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_dist_rx.md
Name: uart_dist_rx

Overview:
- Host-side receiving end of the distance telemetry link.
- Deserialises the 8N1 UART stream sent by the measurement board.
- Pairs consecutive bytes (low byte first, then high byte) back into the 16-bit distance word.
- Presents the word with a one-cycle valid strobe; used in loopback/verification boards and in the bridge that forwards distance readings to other logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s; BIT_DIV = CLK_FREQ / BAUD_RATE, truncated (434 at defaults).
- TIMEOUT_BITS, 20, idle bit-times allowed between the low and high byte of one word.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- rx_byte  output  8  last correctly framed byte.
- rx_byte_valid  output  1  one-cycle pulse when rx_byte updates.
- distance_data  output  16  reassembled word {high byte, low byte}.
- distance_valid  output  1  one-cycle pulse when distance_data updates.
- frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Clock and reset: single clock domain. Asynchronous active-low reset, rst_n, clears all state. Reset values:
  - All outputs 0.
  - Synchroniser flops 1.
  - FSM IDLE, byte index 0.
- Input synchronisation: uart_rx passes through a 2-flop synchroniser. All decisions use the synchronised value, so there are 2 cycles of input latency.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a synchronised high-to-low transition -> START; clear the bit-timer.
- START: at count BIT_DIV/2 - 1 (mid start bit), sample the line.
  - Low -> DATA, timer restart.
  - High -> IDLE (glitch rejected, no pulses).
- DATA: every BIT_DIV cycles, sample one bit into the shift register, LSB first. After 8 bits -> STOP.
- STOP: after BIT_DIV cycles, sample the line.
  - 1: rx_byte <= shift register, rx_byte_valid pulses for 1 cycle, -> IDLE.
  - 0: frame_err pulses for 1 cycle, byte discarded, byte index forced to 0, -> WAIT_HIGH.
- WAIT_HIGH: stay until the synchronised line is 1, then -> IDLE. A break condition therefore produces exactly one frame_err.
- Word assembly (byte index 0/1):
  - Index 0 + valid byte: store as low byte, index <- 1.
  - Index 1 + valid byte: distance_data <= {byte, low}, distance_valid pulses in the cycle after that rx_byte_valid, index <- 0.
  - distance_data holds between updates.
- Inter-byte timeout: counter cleared on each rx_byte_valid. It counts only while index = 1 and the FSM is IDLE.
  - Reaching TIMEOUT_BITS*BIT_DIV: index <- 0, low byte dropped, no pulse.
  - A byte whose start edge arrives on the expiry cycle is treated as a new low byte.
- Counter widths: sized by $clog2 of the largest terminal count. No wrap is possible within a state.
- Reset mid-frame: partial byte and pending low byte are lost. Reception resumes at the next falling edge after rst_n deasserts.

Optional Feature:
- Macro: UART_DIST_RX_TIMEOUT_EN.
- Defined: inter-byte timeout active as described under Behaviour.
- Undefined: timeout counter absent. Pairing resynchronises only on frame_err or reset; a lost byte shifts the pairing until one of these occurs.

Test Plan:
- Defaults; send bytes 0x34 then 0x12 back-to-back -> rx_byte_valid twice (0x34, 0x12); distance_valid once with distance_data = 0x1234; frame_err never asserted.
- Send 0xA5 with stop bit driven 0, then 0x01, 0x00 -> one frame_err; no rx_byte_valid for 0xA5; distance_data = 0x0001.
- 100-cycle low glitch on idle line -> FSM returns to IDLE; no rx_byte_valid, no frame_err.
- Timeout enabled: send 0x11, idle 25 bit-times, send 0x22, 0x33 -> distance_data = 0x3322; the 0x11 byte is discarded.
- Timeout disabled: same stimulus -> distance_data = 0x2211.
- Assert rst_n low during bit 4 of the second byte, release, send 0x78, 0x56 -> outputs 0 during reset; then distance_data = 0x5678.
- 32 random words at 115200 baud with ±2% rate offset -> every word received intact with no frame_err.
